tuple_unpack_pipe: RTL and testbench
====================================

# tuple_unpack_pipe

Elastic pipeline that unpacks a stream of 8-bit packed words into two 4-bit tuple fields; the receive-side counterpart of the tuple-packing `delay_3` pipeline. Upper nibble becomes field `first`, lower nibble `second`. Valid/ready on both sides, full-throughput streaming, backpressure stalls without data loss. A wrapping transfer counter supports bench and system-level accounting.

## Interface

Parameters:
- `STAGES`, 3: number of register stages, ≥1; equals no-stall latency in cycles.
- `CNT_W`, 8: width of the transfer counter.

Ports:
- `_i_clk`  in  1  clock; all state updates on rising edge.
- `_i_rst_n`  in  1  reset, asynchronous, active-low.
- `_i_in_valid`  in  1  upstream word valid.
- `_i_in_data`  in  8  packed word `{first[3:0], second[3:0]}`.
- `_o_in_ready`  out  1  block can accept a word this cycle.
- `_o_out_valid`  out  1  output tuple valid.
- `_o_first`  out  4  `_i_in_data[7:4]` of the word at the pipeline head.
- `_o_second`  out  4  `_i_in_data[3:0]` of the word at the pipeline head.
- `_i_out_ready`  in  1  downstream accepts tuple.
- `_o_count`  out  CNT_W  number of completed output transfers, modulo 2^CNT_W.
- `_o_parity`  out  1  only with `TUPLE_UNPACK_PARITY_EN`: XOR of all 8 bits of the head word.

## Operation

- Stages 0..STAGES-1, each holding valid bit + 8-bit data; stage 0 fed from input, stage STAGES-1 drives outputs.
- Stage k advances when it is empty or its successor advances; last stage advances when `_o_out_valid && _i_out_ready`.
- Input transfer: `_i_in_valid && _o_in_ready` at rising edge; word loaded into stage 0.
- `_o_in_ready` = stage 0 empty or stage 0 advancing (combinational from valid bits and `_i_out_ready`; no path from `_i_in_valid`).
- Output transfer: `_o_out_valid && _i_out_ready`; `_o_count` increments by 1, wraps from 2^CNT_W-1 to 0.
- Fields are direct slices of the stage STAGES-1 data register; no arithmetic.
- While `_o_out_valid` high and `_i_out_ready` low, `_o_first`/`_o_second` hold stable.
- Bubbles compress: an empty stage is filled even while downstream stalls, so up to STAGES words are buffered.
- Word order preserved; no word dropped or duplicated.

## Timing

- Reset (async assert, any time, including mid-stream): all valid bits 0, data registers 0, `_o_count` 0, `_o_out_valid` 0, `_o_first`/`_o_second` 0, `_o_parity` 0; `_o_in_ready` reads 1 while empty. In-flight words discarded.
- Reset release is synchronous to `_i_clk`; first transfer possible on the first rising edge with `_i_rst_n` high.
- Latency, no stall: word accepted at edge N shows on outputs after edge N+STAGES-1 (valid through STAGES cycles counting the acceptance cycle; 3 for default).
- Throughput: one word per cycle with `_i_out_ready` held high.
- Full (all stages valid, `_i_out_ready` low): `_o_in_ready` 0; simultaneous full and `_i_out_ready` high: `_o_in_ready` 1, input and output transfer on the same edge.
- Empty: `_o_out_valid` 0; outputs keep last data (not required to be 0).

## Configuration

- `TUPLE_UNPACK_PARITY_EN` defined: port `_o_parity` exists, registered alongside data through every stage, reset 0, = ^data of head word.
- Not defined: no `_o_parity` port, no parity registers; all other behaviour identical.

## Test plan

- Reset: hold `_i_rst_n`=0 two cycles -> `_o_out_valid`=0, `_o_count`=0, `_o_in_ready`=1.
- Single word 0x1A, `_i_out_ready`=1 -> `_o_first`=1, `_o_second`=0xA, `_o_out_valid` for one cycle 3 cycles after acceptance; `_o_count`=1.
- Stream 0x00..0x0F back-to-back, `_i_out_ready`=1 -> 16 tuples in order, one per cycle, `_o_count`=16.
- Backpressure: `_i_out_ready`=0, offer 0x12,0x34,0x56,0x78 -> first three accepted, `_o_in_ready`=0 for 0x78; release -> tuples (1,2),(3,4),(5,6),(7,8) in order, data stable during stall.
- Counter wrap: 257 transfers -> `_o_count`=1.
- Reset mid-stream with 2 words in flight -> outputs cleared immediately (async); with `TUPLE_UNPACK_PARITY_EN`, word 0x07 -> `_o_parity`=1, 0x03 -> 0.

Source files
------------

// File: rtl/tuple_unpack_pipe.sv
// Elastic valid/ready pipeline that unpacks 8-bit words into two 4-bit fields.
// Optional head-word parity output when TUPLE_UNPACK_PARITY_EN is defined.

module tuple_unpack_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q;
    logic [W-1:0] data_q;

    // Data only moves when a real word arrives, so an emptied stage keeps its last word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q <= vld_i;
            if (vld_i) data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

module tuple_unpack_pipe #(
    parameter int STAGES = 3,
    parameter int CNT_W  = 8
) (
    input  logic             _i_clk,
    input  logic             _i_rst_n,
    input  logic             _i_in_valid,
    input  logic [7:0]       _i_in_data,
    output logic             _o_in_ready,
    output logic             _o_out_valid,
    output logic [3:0]       _o_first,
    output logic [3:0]       _o_second,
    input  logic             _i_out_ready,
    output logic [CNT_W-1:0] _o_count
`ifdef TUPLE_UNPACK_PARITY_EN
    ,
    output logic             _o_parity
`endif
);
`ifdef TUPLE_UNPACK_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif

    logic [W-1:0]             in_word;
    logic [STAGES-1:0]        vld;
    logic [STAGES-1:0]        load;
    logic [STAGES-1:0][W-1:0] dat;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     out_xfer;

`ifdef TUPLE_UNPACK_PARITY_EN
    assign in_word = {^_i_in_data, _i_in_data};
`else
    assign in_word = _i_in_data;
`endif

    // A stage loads when it is empty or its successor is loading; resolved tail to head.
    always_comb begin
        load = '0;
        load[STAGES-1] = ~vld[STAGES-1] | _i_out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = ~vld[k] | load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            tuple_unpack_stage #(.W(W)) u_stg (
                .clk_i   (_i_clk),
                .rst_n_i (_i_rst_n),
                .load_i  (load[k]),
                .vld_i   (_i_in_valid),
                .data_i  (in_word),
                .vld_o   (vld[k]),
                .data_o  (dat[k])
            );
        end else begin : g_body
            tuple_unpack_stage #(.W(W)) u_stg (
                .clk_i   (_i_clk),
                .rst_n_i (_i_rst_n),
                .load_i  (load[k]),
                .vld_i   (vld[k-1]),
                .data_i  (dat[k-1]),
                .vld_o   (vld[k]),
                .data_o  (dat[k])
            );
        end
    end

    assign out_xfer = vld[STAGES-1] & _i_out_ready;

    always_comb begin
        count_d = count_q;
        if (out_xfer) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) count_q <= '0;
        else           count_q <= count_d;
    end

    assign _o_in_ready  = load[0];
    assign _o_out_valid = vld[STAGES-1];
    assign _o_first     = dat[STAGES-1][7:4];
    assign _o_second    = dat[STAGES-1][3:0];
    assign _o_count     = count_q;
`ifdef TUPLE_UNPACK_PARITY_EN
    assign _o_parity    = dat[STAGES-1][8];
`endif
endmodule

// File: tb/tb_tuple_unpack_pipe.sv
// Scoreboard bench for tuple_unpack_pipe: latency, streaming, backpressure, wrap, async reset.
// Build with TUPLE_UNPACK_PARITY_EN to also check the parity output.

module tb_tuple_unpack_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] first, second;
    logic       out_ready;
    logic [7:0] count;
`ifdef TUPLE_UNPACK_PARITY_EN
    logic       parity;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    int         n_cyc = 0;
    logic       acc;
    logic [7:0] exp_cnt;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    tuple_unpack_pipe #(.STAGES(3), .CNT_W(8)) dut (
        ._i_clk       (clk),
        ._i_rst_n     (rst_n),
        ._i_in_valid  (in_valid),
        ._i_in_data   (in_data),
        ._o_in_ready  (in_ready),
        ._o_out_valid (out_valid),
        ._o_first     (first),
        ._o_second    (second),
        ._i_out_ready (out_ready),
        ._o_count     (count)
`ifdef TUPLE_UNPACK_PARITY_EN
        ,
        ._o_parity    (parity)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: note transfers that the coming edge will perform, then advance to the next negedge.
    task automatic cyc();
        logic [7:0] h;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(in_data);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                h = sb[0];
                chk("first", {28'd0, first}, {28'd0, h[7:4]});
                chk("second", {28'd0, second}, {28'd0, h[3:0]});
`ifdef TUPLE_UNPACK_PARITY_EN
                chk("parity", {31'd0, parity}, {31'd0, ^h});
`endif
                if (out_ready) begin
                    void'(sb.pop_front());
                    exp_cnt++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cyc();
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        exp_cnt   = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_count", {24'd0, count}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;

        // single word latency
        in_valid = 1'b1;
        in_data  = 8'h1A;
        cyc();
        chk("single_acc", {31'd0, acc}, 1);
        in_valid = 1'b0;
        chk("lat_e0", {31'd0, out_valid}, 0);
        cyc();
        chk("lat_e1", {31'd0, out_valid}, 0);
        cyc();
        chk("lat_e2", {31'd0, out_valid}, 1);
        chk("single_first", {28'd0, first}, 32'h1);
        chk("single_second", {28'd0, second}, 32'hA);
        cyc();
        chk("single_done", {31'd0, out_valid}, 0);
        chk("single_count", {24'd0, count}, 1);

        // back-to-back stream
        c0 = n_cyc;
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("stream_tput", n_cyc - c0, 16);
        drain();
        chk("stream_count", {24'd0, count}, 17);
        chk("stream_model_cnt", {24'd0, count}, {24'd0, exp_cnt});

        // backpressure with bubble compression
        do_reset();
        out_ready = 1'b0;
        send(8'h12);
        send(8'h34);
        send(8'h56);
        in_valid = 1'b1;
        in_data  = 8'h78;
        #1;
        chk("full_in_ready", {31'd0, in_ready}, 0);
        chk("full_out_valid", {31'd0, out_valid}, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_noacc", {31'd0, acc}, 0);
        end
        chk("stall_first", {28'd0, first}, 32'h1);
        chk("stall_second", {28'd0, second}, 32'h2);
        out_ready = 1'b1;
        #1;
        chk("full_release_ready", {31'd0, in_ready}, 1);
        cyc();
        chk("release_acc", {31'd0, acc}, 1);
        in_valid = 1'b0;
        drain();
        chk("bp_count", {24'd0, count}, 4);

        // counter wrap
        do_reset();
        for (int i = 0; i < 257; i++) send(8'(i * 7));
        drain();
        chk("wrap_count", {24'd0, count}, 1);
        chk("wrap_model_cnt", {24'd0, count}, {24'd0, exp_cnt});

        // parity patterns (data checked in the default build too)
        send(8'h07);
        send(8'h03);
        drain();
        chk("par_count", {24'd0, count}, 3);

        // async reset mid-stream with two words in flight
        out_ready = 1'b0;
        send(8'hC5);
        send(8'h3E);
        cyc();
        chk("pre_rst_valid", {31'd0, out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_count", {24'd0, count}, 0);
        chk("mid_rst_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_first", {28'd0, first}, 0);
        chk("mid_rst_second", {28'd0, second}, 0);
`ifdef TUPLE_UNPACK_PARITY_EN
        chk("mid_rst_parity", {31'd0, parity}, 0);
`endif
        sb.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(8'h9B);
        drain();
        chk("post_rst_count", {24'd0, count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
